fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the asynchronous FIFO write port (W_INC/WR_DATA/FULL)

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 82 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between NUM_REQ requesters, the arbiter and the async FIFO write side.
// The master modport is the arbiter, which drives the FIFO write port and the per-requester accepts.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          w_inc;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [SEL_WIDTH-1:0]          grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, full,
    output req_ready, w_inc, wr_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, full,
    input  req_ready, w_inc, wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters,
// granting bursts of up to MAX_BURST words and never writing while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  fifo_wr_arbiter_if.master   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [SEL_WIDTH-1:0]  owner;
  logic [SEL_WIDTH-1:0]  last;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [SEL_WIDTH-1:0]  pick;
  logic [SEL_WIDTH-1:0]  cand;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from farthest to nearest after 'last' so the closest valid requester overwrites the rest.
  always_comb begin
    pick = last;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = SEL_WIDTH'((int'(last) + k) % NUM_REQ);
      if (bus.req_valid[cand]) pick = cand;
    end
  end

  assign xfer         = (state == GRANT) && bus.req_valid[owner] && !bus.full;
  assign bus.w_inc     = xfer;
  assign bus.req_ready = xfer ? (NUM_REQ'(1) << owner) : '0;
  assign bus.wr_data   = (state == GRANT) ? words[owner] : '0;
  assign bus.grant_id  = owner;
  assign bus.busy      = (state == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= SEL_WIDTH'(NUM_REQ - 1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            state <= GRANT;
            owner <= pick;
            last  <= pick;
            cnt   <= '0;
          end
        end
        GRANT: begin
          // A full FIFO with the owner still valid falls through untouched: the grant is held.
          if (!bus.req_valid[owner]) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!bus.full) begin
            if (cnt == CNT_WIDTH'(MAX_BURST - 1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester models feed word queues, the expected
// write order and burst lengths are queued up front and checked as the DUT writes.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .SEL_WIDTH(2)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .SEL_WIDTH(2), .MAX_BURST(4), .CNT_WIDTH(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] src  [NUM_REQ][$];
  logic [DW-1:0] pend [NUM_REQ][$];
  exp_t          exp_q[$];
  int            exp_burst[$];

  int n_checks = 0;
  int n_fail   = 0;
  int writes   = 0;
  int cur_burst = 0;
  logic prev_busy = 1'b0;
  int stall_at   = -1;
  int stall_left = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic load(input int id, input int n);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = DW'($urandom_range(0, 255));
      src[id].push_back(w);
      pend[id].push_back(w);
    end
  endtask

  // Queue the next n words of requester id as one expected burst.
  task automatic expect_burst(input int id, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = 2'(id);
      e.data = pend[id].pop_front();
      exp_q.push_back(e);
    end
    exp_burst.push_back(n);
  endtask

  task automatic applyStimulus();
    logic [NUM_REQ-1:0]    v;
    logic [NUM_REQ*DW-1:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src[i].size() > 0) begin
        v = v | (NUM_REQ'(1) << i);
        d = d | ((NUM_REQ*DW)'(src[i][0]) << (DW * i));
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.full      = (stall_left > 0);
  endtask

  task automatic monitor();
    logic [NUM_REQ-1:0] rdy;
    exp_t e;
    rdy = bus.req_ready;
    if (bus.full) begin
      checkOutput("w_inc_while_full", 32'(bus.w_inc), 32'(0));
      checkOutput("ready_while_full", 32'(rdy), 32'(0));
      checkOutput("busy_during_stall", 32'(bus.busy), 32'(1));
    end
    if (bus.w_inc) begin
      writes++;
      cur_burst++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 32'(bus.w_inc), 32'(0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_data", 32'(bus.wr_data), 32'(e.data));
        checkOutput("grant_id", 32'(bus.grant_id), 32'(e.id));
        checkOutput("req_ready", 32'(rdy), 32'(NUM_REQ'(1) << e.id));
      end
      if (writes == stall_at) stall_left = 5;
    end else if (!bus.full) begin
      checkOutput("ready_no_write", 32'(rdy), 32'(0));
    end
    if (!bus.busy) checkOutput("wr_data_idle", 32'(bus.wr_data), 32'(0));
    if (prev_busy && !bus.busy) begin
      if (exp_burst.size() == 0) checkOutput("unexpected_burst", 32'(cur_burst), 32'(0));
      else checkOutput("burst_len", 32'(cur_burst), 32'(exp_burst.pop_front()));
      cur_burst = 0;
    end
    prev_busy = bus.busy;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (((rdy >> i) & NUM_REQ'(1)) != '0 && src[i].size() > 0) void'(src[i].pop_front());
    end
  endtask

  task automatic cycle_once();
    @(negedge clk);
    applyStimulus();
    #1;
    monitor();
    if (bus.full) stall_left--;
  endtask

  task automatic run_until_done(input int budget);
    int c = 0;
    while ((exp_q.size() > 0 || exp_burst.size() > 0) && c < budget) begin
      cycle_once();
      c++;
    end
    checkOutput("pending_words", 32'(exp_q.size()), 32'(0));
    checkOutput("pending_bursts", 32'(exp_burst.size()), 32'(0));
  endtask

  task automatic run_until_writes(input int n, input int budget);
    int c = 0;
    while (writes < n && c < budget) begin
      cycle_once();
      c++;
    end
    checkOutput("writes_reached", 32'(writes), 32'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src[i].delete();
      pend[i].delete();
    end
    exp_q.delete();
    exp_burst.delete();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.full      = 1'b0;
    stall_at   = -1;
    stall_left = 0;
    writes     = 0;
    cur_burst  = 0;
    prev_busy  = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.full      = 1'b0;

    $display("[TB] reset with all requesters valid");
    for (int i = 0; i < NUM_REQ; i++) load(i, 1);
    cycle_once();
    cycle_once();
    checkOutput("rst_w_inc", 32'(bus.w_inc), 32'(0));
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'(0));
    checkOutput("rst_busy", 32'(bus.busy), 32'(0));
    checkOutput("rst_grant_id", 32'(bus.grant_id), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) expect_burst(i, 1);
    run_until_done(100);

    $display("[TB] single requester, 10 words");
    do_reset();
    load(2, 10);
    expect_burst(2, 4);
    expect_burst(2, 4);
    expect_burst(2, 2);
    run_until_done(200);

    $display("[TB] round robin, all valid");
    do_reset();
    load(0, 8);
    for (int i = 1; i < NUM_REQ; i++) load(i, 4);
    for (int i = 0; i < NUM_REQ; i++) expect_burst(i, 4);
    expect_burst(0, 4);
    run_until_done(300);

    $display("[TB] full stall at second word");
    do_reset();
    stall_at = 1;
    load(1, 6);
    expect_burst(1, 4);
    expect_burst(1, 2);
    run_until_done(200);

    $display("[TB] early release");
    do_reset();
    load(0, 1);
    load(2, 5);
    expect_burst(0, 1);
    expect_burst(2, 4);
    expect_burst(2, 1);
    run_until_done(200);

    $display("[TB] reset mid-burst");
    do_reset();
    load(1, 6);
    expect_burst(1, 2);
    run_until_writes(2, 50);
    @(negedge clk);
    applyStimulus();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_w_inc", 32'(bus.w_inc), 32'(0));
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'(0));
    checkOutput("midrst_busy", 32'(bus.busy), 32'(0));
    checkOutput("midrst_grant_id", 32'(bus.grant_id), 32'(0));
    load(0, 3);
    cycle_once();
    cycle_once();
    rst_n = 1'b1;
    expect_burst(0, 3);
    expect_burst(1, 4);
    run_until_done(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
